// File: rtl/bytewrite_sp_ram_pipe_pkg.sv
// Shared types for the pipelined byte-write single-port RAM.
//   rdw_mode_e  : read-during-write behaviour of the response word
//   ram_state_e : controller state (clear sweep / normal operation)
//   lane_off_width() : number of byte-offset address bits for a lane count
package bytewrite_pkg;

  typedef enum logic {
    READ_FIRST  = 1'b0,
    WRITE_FIRST = 1'b1
  } rdw_mode_e;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ram_state_e;

  function automatic int unsigned lane_off_width(input int unsigned numCol);
    return (numCol > 1) ? $clog2(numCol) : 0;
  endfunction

endpackage

// File: rtl/bytewrite_sp_ram_pipe_if.sv
// Request/response bus of the pipelined byte-write RAM.
//   master : requester side (drives req_valid/req_we/req_addr/req_wdata)
//   slave  : RAM side (drives req_ready, rsp_valid/rsp_rdata/rsp_err, init_done)
interface bytewrite_sp_ram_pipe_if #(
  parameter int unsigned NUM_COL    = 4,
  parameter int unsigned COL_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = 8
);
  localparam int unsigned DATA_WIDTH = NUM_COL * COL_WIDTH;

  logic                  req_valid;
  logic                  req_ready;
  logic [NUM_COL-1:0]    req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  init_done;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );
endinterface

// File: rtl/bytewrite_sp_ram_pipe_core.sv
// Storage array for the byte-write RAM: per-lane write enables and one
// synchronous read port sharing the single address. Read returns the word
// as it was before this edge's write. No reset on the array or read data.
//   clk   : clock
//   en    : access enable (write lanes and capture read data)
//   we    : per-lane write enable
//   addr  : word index
//   wdata : write data, lane i at [i*COL_WIDTH +: COL_WIDTH]
//   rdata : registered read data
module bytewrite_ram_core #(
  parameter int unsigned NUM_COL   = 4,
  parameter int unsigned COL_WIDTH = 8,
  parameter int unsigned WORD_AW   = 6
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic [NUM_COL-1:0]             we,
  input  logic [WORD_AW-1:0]             addr,
  input  logic [NUM_COL*COL_WIDTH-1:0]   wdata,
  output logic [NUM_COL*COL_WIDTH-1:0]   rdata
);
  localparam int unsigned DW    = NUM_COL * COL_WIDTH;
  localparam int unsigned DEPTH = 2 ** WORD_AW;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int unsigned i = 0; i < NUM_COL; i++) begin
        if (we[i]) begin
          mem[addr][i*COL_WIDTH +: COL_WIDTH] <= wdata[i*COL_WIDTH +: COL_WIDTH];
        end
      end
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/bytewrite_sp_ram_pipe.sv
// Pipelined single-port byte-write RAM with request/response handshake.
// After reset every word is cleared (one word per cycle), then requests are
// accepted every cycle. Each accepted request yields one rsp_valid pulse
// READ_LATENCY cycles later carrying the word (old or merged per RDW_MODE)
// and a misalignment flag when ALIGN_CHECK is set.
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : request/response bus (slave side), see bytewrite_sp_ram_pipe_if
module bytewrite_sp_ram_pipe
  import bytewrite_pkg::*;
#(
  parameter int unsigned NUM_COL      = 4,
  parameter int unsigned COL_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = NUM_COL * COL_WIDTH,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned RDW_MODE     = 0,
  parameter int unsigned ALIGN_CHECK  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  bytewrite_sp_ram_pipe_if.slave bus
);
  localparam int unsigned OFF_W    = lane_off_width(NUM_COL);
  localparam int unsigned WORD_AW  = ADDR_WIDTH - OFF_W;
  localparam rdw_mode_e   RDW      = (RDW_MODE != 0) ? WRITE_FIRST : READ_FIRST;
  localparam bit          ALIGN_EN = (ALIGN_CHECK != 0);
  localparam logic [WORD_AW-1:0] CLR_LAST = '1;

  ram_state_e state, stateNext;
  logic [WORD_AW-1:0] clrCnt;
  logic reqReady, clearing;

  logic [WORD_AW-1:0] wordIdx;
  logic misaligned, accept, reject;

  logic                  ramEn;
  logic [NUM_COL-1:0]    ramWe;
  logic [WORD_AW-1:0]    ramAddr;
  logic [DATA_WIDTH-1:0] ramWdata, ramRdata;

  logic                  s1Valid, s1Have, s1Err;
  logic [NUM_COL-1:0]    s1We;
  logic [DATA_WIDTH-1:0] s1Wdata, s1Data;

  // Controller
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    reqReady  = 1'b0;
    clearing  = 1'b0;
    unique case (state)
      INIT: begin
        clearing = 1'b1;
        if (clrCnt == CLR_LAST) stateNext = RUN;
      end
      RUN:     reqReady = 1'b1;
      default: stateNext = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clrCnt <= '0;
    end else if (clearing) begin
      clrCnt <= clrCnt + WORD_AW'(1);
    end
  end

  // Address decode
  assign wordIdx = bus.req_addr[ADDR_WIDTH-1 -: WORD_AW];

  generate
    if (OFF_W > 0) begin : g_off
      assign misaligned = |bus.req_addr[OFF_W-1:0];
    end else begin : g_nooff
      assign misaligned = 1'b0;
    end
  endgenerate

  // A request presented on a reset cycle is dropped, so its write never lands.
  assign accept = bus.req_valid & reqReady & ~reset;
  assign reject = ALIGN_EN & misaligned;

  // Storage port: the clear sweep owns it during INIT.
  always_comb begin
    ramEn    = clearing | accept;
    ramWe    = '0;
    ramAddr  = wordIdx;
    ramWdata = bus.req_wdata;
    if (clearing) begin
      ramWe    = '1;
      ramAddr  = clrCnt;
      ramWdata = '0;
    end else if (accept && !reject) begin
      ramWe = bus.req_we;
    end
  end

  bytewrite_ram_core #(
    .NUM_COL   (NUM_COL),
    .COL_WIDTH (COL_WIDTH),
    .WORD_AW   (WORD_AW)
  ) u_core (
    .clk   (clk),
    .en    (ramEn),
    .we    (ramWe),
    .addr  (ramAddr),
    .wdata (ramWdata),
    .rdata (ramRdata)
  );

  // Stage 1: side-band travelling with the core's registered read data.
  // A rejected write keeps a zero lane mask so its response shows the old word.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1Valid <= 1'b0;
      s1Have  <= 1'b0;
      s1Err   <= 1'b0;
      s1We    <= '0;
      s1Wdata <= '0;
    end else begin
      s1Valid <= accept;
      if (accept) begin
        s1Have  <= 1'b1;
        s1Err   <= reject;
        s1We    <= reject ? '0 : bus.req_we;
        s1Wdata <= bus.req_wdata;
      end
    end
  end

  // The core read data has no reset; s1Have masks it to zero until the
  // first response after reset.
  always_comb begin
    s1Data = ramRdata;
    if (RDW == WRITE_FIRST) begin
      for (int unsigned i = 0; i < NUM_COL; i++) begin
        if (s1We[i]) s1Data[i*COL_WIDTH +: COL_WIDTH] = s1Wdata[i*COL_WIDTH +: COL_WIDTH];
      end
    end
    if (!s1Have) s1Data = '0;
  end

  // Optional second output stage
  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  s2Valid, s2Err;
      logic [DATA_WIDTH-1:0] s2Data;

      always_ff @(posedge clk) begin
        if (reset) begin
          s2Valid <= 1'b0;
          s2Err   <= 1'b0;
          s2Data  <= '0;
        end else begin
          s2Valid <= s1Valid;
          if (s1Valid) begin
            s2Err  <= s1Err;
            s2Data <= s1Data;
          end
        end
      end

      assign bus.rsp_valid = s2Valid;
      assign bus.rsp_rdata = s2Data;
      assign bus.rsp_err   = s2Err;
    end else begin : g_lat1
      assign bus.rsp_valid = s1Valid;
      assign bus.rsp_rdata = s1Data;
      assign bus.rsp_err   = s1Err;
    end
  endgenerate

  assign bus.req_ready = reqReady;
  assign bus.init_done = reqReady;
endmodule

// File: tb/tb_bytewrite_sp_ram_pipe.sv
// Bench for bytewrite_sp_ram_pipe. Two instances share one stimulus stream:
//   A: READ_LATENCY=1, read-first,  misaligned accesses rejected
//   B: READ_LATENCY=2, write-first, misaligned low bits ignored
// Expected responses come from a word-array model of the memory rules.
module tb_bytewrite_sp_ram_pipe;
  localparam int unsigned DEPTH = 64;

  typedef struct packed {
    logic [7:0]  a;
    logic [3:0]  w;
    logic [31:0] d;
    logic [31:0] xa;
    logic        ea;
    logic [31:0] xb;
    logic        eb;
  } req_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reqValid = 1'b0;
  logic [3:0]  reqWe = '0;
  logic [7:0]  reqAddr = '0;
  logic [31:0] reqWdata = '0;

  int nChecks = 0;
  int nErrors = 0;

  logic [31:0] memA [DEPTH];
  logic [31:0] memB [DEPTH];
  logic [31:0] lastA, lastB;
  logic        lastEA, lastEB;

  always #5 clk = ~clk;

  bytewrite_sp_ram_pipe_if #(.NUM_COL(4), .COL_WIDTH(8), .ADDR_WIDTH(8)) ifA ();
  bytewrite_sp_ram_pipe_if #(.NUM_COL(4), .COL_WIDTH(8), .ADDR_WIDTH(8)) ifB ();

  assign ifA.req_valid = reqValid;
  assign ifA.req_we    = reqWe;
  assign ifA.req_addr  = reqAddr;
  assign ifA.req_wdata = reqWdata;
  assign ifB.req_valid = reqValid;
  assign ifB.req_we    = reqWe;
  assign ifB.req_addr  = reqAddr;
  assign ifB.req_wdata = reqWdata;

  bytewrite_sp_ram_pipe #(
    .NUM_COL(4), .COL_WIDTH(8), .ADDR_WIDTH(8),
    .READ_LATENCY(1), .RDW_MODE(0), .ALIGN_CHECK(1)
  ) dutA (
    .clk   (clk),
    .reset (reset),
    .bus   (ifA.slave)
  );

  bytewrite_sp_ram_pipe #(
    .NUM_COL(4), .COL_WIDTH(8), .ADDR_WIDTH(8),
    .READ_LATENCY(2), .RDW_MODE(1), .ALIGN_CHECK(0)
  ) dutB (
    .clk   (clk),
    .reset (reset),
    .bus   (ifB.slave)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [3:0] we,
                                             input logic [31:0] nw);
    logic [31:0] mask;
    mask = '0;
    for (int b = 0; b < 4; b++) if (we[b]) mask = mask | (32'hFF << (8 * b));
    return (old & ~mask) | (nw & mask);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      memA[i] = '0;
      memB[i] = '0;
    end
  endtask

  task automatic model_access(input logic [7:0] a, input logic [3:0] w, input logic [31:0] d);
    lastEA = (a[1:0] != 2'b00);
    lastA  = memA[a[7:2]];
    if (!lastEA) memA[a[7:2]] = lane_merge(memA[a[7:2]], w, d);
    memB[a[7:2]] = lane_merge(memB[a[7:2]], w, d);
    lastB  = memB[a[7:2]];
    lastEB = 1'b0;
  endtask

  // ---------------- drive helpers (no checking) ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] a, input logic [3:0] w, input logic [31:0] d);
    reqValid = 1'b1;
    reqAddr  = a;
    reqWe    = w;
    reqWdata = d;
  endtask

  task automatic idle();
    reqValid = 1'b0;
    reqWe    = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    req_t t[$];
    int n;
    logic expRdy;
    reset = 1'b1;
    issue(8'h14, 4'hF, 32'hFFFF_FFFF);
    step();
    step();
    nChecks++;
    if ({ifA.req_ready, ifA.rsp_valid, ifA.rsp_err, ifA.init_done} !== 4'b0000 || ifA.rsp_rdata !== 32'h0) begin
      nErrors++;
      $display("FAIL reset_A: ready=%b valid=%b err=%b done=%b rdata=%h, required all zero",
               ifA.req_ready, ifA.rsp_valid, ifA.rsp_err, ifA.init_done, ifA.rsp_rdata);
    end
    nChecks++;
    if ({ifB.req_ready, ifB.rsp_valid, ifB.rsp_err, ifB.init_done} !== 4'b0000 || ifB.rsp_rdata !== 32'h0) begin
      nErrors++;
      $display("FAIL reset_B: ready=%b valid=%b err=%b done=%b rdata=%h, required all zero",
               ifB.req_ready, ifB.rsp_valid, ifB.rsp_err, ifB.init_done, ifB.rsp_rdata);
    end
    // req_valid stays high through the sweep and must be ignored
    reset = 1'b0;
    model_clear();
    for (int k = 1; k <= DEPTH; k++) begin
      step();
      expRdy = (k == DEPTH);
      nChecks++;
      if (ifA.req_ready !== expRdy || ifA.init_done !== expRdy) begin
        nErrors++;
        $display("FAIL sweep_A cycle %0d: ready=%b done=%b, required %b", k, ifA.req_ready, ifA.init_done, expRdy);
      end
      nChecks++;
      if (ifB.req_ready !== expRdy || ifB.init_done !== expRdy) begin
        nErrors++;
        $display("FAIL sweep_B cycle %0d: ready=%b done=%b, required %b", k, ifB.req_ready, ifB.init_done, expRdy);
      end
      nChecks++;
      if (ifA.rsp_valid !== 1'b0 || ifB.rsp_valid !== 1'b0) begin
        nErrors++;
        $display("FAIL sweep_norsp cycle %0d: validA=%b validB=%b, required 0", k, ifA.rsp_valid, ifB.rsp_valid);
      end
    end
    idle();
    // read of word 5 after the clear
    t.push_back('{8'h14, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0});
    foreach (t[i]) model_access(t[i].a, t[i].w, t[i].d);
    n = t.size();
    for (int k = 0; k <= n; k++) begin
      if (k < n) issue(t[k].a, t[k].w, t[k].d); else idle();
      step();
      nChecks++;
      if (ifA.rsp_valid !== (k < n)) begin
        nErrors++; $display("FAIL clr_validA k=%0d: got %b, required %b", k, ifA.rsp_valid, (k < n));
      end
      if (k < n) begin
        nChecks++;
        if (ifA.rsp_rdata !== t[k].xa || ifA.rsp_err !== t[k].ea) begin
          nErrors++; $display("FAIL clr_dataA k=%0d: got %h err=%b, required %h err=%b", k, ifA.rsp_rdata, ifA.rsp_err, t[k].xa, t[k].ea);
        end
      end
      nChecks++;
      if (ifB.rsp_valid !== (k >= 1)) begin
        nErrors++; $display("FAIL clr_validB k=%0d: got %b, required %b", k, ifB.rsp_valid, (k >= 1));
      end
      if (k >= 1) begin
        nChecks++;
        if (ifB.rsp_rdata !== t[k-1].xb || ifB.rsp_err !== t[k-1].eb) begin
          nErrors++; $display("FAIL clr_dataB k=%0d: got %h err=%b, required %h err=%b", k, ifB.rsp_rdata, ifB.rsp_err, t[k-1].xb, t[k-1].eb);
        end
      end
    end
  endtask

  task automatic test_lane_merge();
    req_t t[$];
    int n;
    t.push_back('{8'h10, 4'b1111, 32'hDEADBEEF, 32'h00000000, 1'b0, 32'hDEADBEEF, 1'b0});
    t.push_back('{8'h10, 4'b0010, 32'h00001100, 32'hDEADBEEF, 1'b0, 32'hDEAD11EF, 1'b0});
    t.push_back('{8'h10, 4'b0000, 32'h00000000, 32'hDEAD11EF, 1'b0, 32'hDEAD11EF, 1'b0});
    foreach (t[i]) model_access(t[i].a, t[i].w, t[i].d);
    n = t.size();
    for (int k = 0; k <= n; k++) begin
      if (k < n) issue(t[k].a, t[k].w, t[k].d); else idle();
      step();
      nChecks++;
      if (ifA.rsp_valid !== (k < n)) begin
        nErrors++; $display("FAIL merge_validA k=%0d: got %b, required %b", k, ifA.rsp_valid, (k < n));
      end
      if (k < n) begin
        nChecks++;
        if (ifA.rsp_rdata !== t[k].xa || ifA.rsp_err !== t[k].ea) begin
          nErrors++; $display("FAIL merge_dataA k=%0d: got %h err=%b, required %h err=%b", k, ifA.rsp_rdata, ifA.rsp_err, t[k].xa, t[k].ea);
        end
      end
      nChecks++;
      if (ifB.rsp_valid !== (k >= 1)) begin
        nErrors++; $display("FAIL merge_validB k=%0d: got %b, required %b", k, ifB.rsp_valid, (k >= 1));
      end
      if (k >= 1) begin
        nChecks++;
        if (ifB.rsp_rdata !== t[k-1].xb || ifB.rsp_err !== t[k-1].eb) begin
          nErrors++; $display("FAIL merge_dataB k=%0d: got %h err=%b, required %h err=%b", k, ifB.rsp_rdata, ifB.rsp_err, t[k-1].xb, t[k-1].eb);
        end
      end
    end
  endtask

  task automatic test_rdw_mode();
    req_t t[$];
    int n;
    t.push_back('{8'h20, 4'b1111, 32'h11223344, 32'h00000000, 1'b0, 32'h11223344, 1'b0});
    t.push_back('{8'h20, 4'b0001, 32'h000000AA, 32'h11223344, 1'b0, 32'h112233AA, 1'b0});
    t.push_back('{8'h20, 4'b0000, 32'h00000000, 32'h112233AA, 1'b0, 32'h112233AA, 1'b0});
    foreach (t[i]) model_access(t[i].a, t[i].w, t[i].d);
    n = t.size();
    for (int k = 0; k <= n; k++) begin
      if (k < n) issue(t[k].a, t[k].w, t[k].d); else idle();
      step();
      nChecks++;
      if (ifA.rsp_valid !== (k < n)) begin
        nErrors++; $display("FAIL rdw_validA k=%0d: got %b, required %b", k, ifA.rsp_valid, (k < n));
      end
      if (k < n) begin
        nChecks++;
        if (ifA.rsp_rdata !== t[k].xa || ifA.rsp_err !== t[k].ea) begin
          nErrors++; $display("FAIL rdw_dataA k=%0d: got %h err=%b, required %h err=%b", k, ifA.rsp_rdata, ifA.rsp_err, t[k].xa, t[k].ea);
        end
      end
      nChecks++;
      if (ifB.rsp_valid !== (k >= 1)) begin
        nErrors++; $display("FAIL rdw_validB k=%0d: got %b, required %b", k, ifB.rsp_valid, (k >= 1));
      end
      if (k >= 1) begin
        nChecks++;
        if (ifB.rsp_rdata !== t[k-1].xb || ifB.rsp_err !== t[k-1].eb) begin
          nErrors++; $display("FAIL rdw_dataB k=%0d: got %h err=%b, required %h err=%b", k, ifB.rsp_rdata, ifB.rsp_err, t[k-1].xb, t[k-1].eb);
        end
      end
    end
  endtask

  task automatic test_align();
    req_t t[$];
    int n;
    // word 0x10 holds 0xDEAD11EF in both instances here
    t.push_back('{8'h13, 4'b1111, 32'hCAFEF00D, 32'hDEAD11EF, 1'b1, 32'hCAFEF00D, 1'b0});
    t.push_back('{8'h10, 4'b0000, 32'h00000000, 32'hDEAD11EF, 1'b0, 32'hCAFEF00D, 1'b0});
    t.push_back('{8'h12, 4'b0000, 32'h00000000, 32'hDEAD11EF, 1'b1, 32'hCAFEF00D, 1'b0});
    foreach (t[i]) model_access(t[i].a, t[i].w, t[i].d);
    n = t.size();
    for (int k = 0; k <= n; k++) begin
      if (k < n) issue(t[k].a, t[k].w, t[k].d); else idle();
      step();
      nChecks++;
      if (ifA.rsp_valid !== (k < n)) begin
        nErrors++; $display("FAIL align_validA k=%0d: got %b, required %b", k, ifA.rsp_valid, (k < n));
      end
      if (k < n) begin
        nChecks++;
        if (ifA.rsp_rdata !== t[k].xa || ifA.rsp_err !== t[k].ea) begin
          nErrors++; $display("FAIL align_dataA k=%0d: got %h err=%b, required %h err=%b", k, ifA.rsp_rdata, ifA.rsp_err, t[k].xa, t[k].ea);
        end
      end
      nChecks++;
      if (ifB.rsp_valid !== (k >= 1)) begin
        nErrors++; $display("FAIL align_validB k=%0d: got %b, required %b", k, ifB.rsp_valid, (k >= 1));
      end
      if (k >= 1) begin
        nChecks++;
        if (ifB.rsp_rdata !== t[k-1].xb || ifB.rsp_err !== t[k-1].eb) begin
          nErrors++; $display("FAIL align_dataB k=%0d: got %h err=%b, required %h err=%b", k, ifB.rsp_rdata, ifB.rsp_err, t[k-1].xb, t[k-1].eb);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    req_t t[$];
    req_t e;
    int n;
    for (int i = 0; i < 16; i++) begin
      e.a = {4'b0001, 2'($urandom_range(0, 3)), 2'b00};
      if ($urandom_range(0, 3) == 0) e.a[1:0] = 2'($urandom_range(1, 3));
      e.w = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      e.d = $urandom;
      model_access(e.a, e.w, e.d);
      e.xa = lastA;
      e.ea = lastEA;
      e.xb = lastB;
      e.eb = lastEB;
      t.push_back(e);
    end
    n = t.size();
    for (int k = 0; k <= n; k++) begin
      if (k < n) issue(t[k].a, t[k].w, t[k].d); else idle();
      step();
      nChecks++;
      if (ifA.rsp_valid !== (k < n)) begin
        nErrors++; $display("FAIL b2b_validA k=%0d: got %b, required %b", k, ifA.rsp_valid, (k < n));
      end
      if (k < n) begin
        nChecks++;
        if (ifA.rsp_rdata !== t[k].xa || ifA.rsp_err !== t[k].ea) begin
          nErrors++; $display("FAIL b2b_dataA k=%0d: got %h err=%b, required %h err=%b", k, ifA.rsp_rdata, ifA.rsp_err, t[k].xa, t[k].ea);
        end
      end
      nChecks++;
      if (ifB.rsp_valid !== (k >= 1)) begin
        nErrors++; $display("FAIL b2b_validB k=%0d: got %b, required %b", k, ifB.rsp_valid, (k >= 1));
      end
      if (k >= 1) begin
        nChecks++;
        if (ifB.rsp_rdata !== t[k-1].xb || ifB.rsp_err !== t[k-1].eb) begin
          nErrors++; $display("FAIL b2b_dataB k=%0d: got %h err=%b, required %h err=%b", k, ifB.rsp_rdata, ifB.rsp_err, t[k-1].xb, t[k-1].eb);
        end
      end
    end
    // one idle cycle: nothing further may appear
    step();
    nChecks++;
    if (ifA.rsp_valid !== 1'b0 || ifB.rsp_valid !== 1'b0) begin
      nErrors++; $display("FAIL b2b_extra: validA=%b validB=%b, required 0", ifA.rsp_valid, ifB.rsp_valid);
    end
  endtask

  task automatic test_reset_midop();
    req_t t[$];
    int n;
    logic expRdy;
    issue(8'h20, 4'h0, 32'h0);
    step();
    issue(8'h10, 4'h0, 32'h0);
    step();
    // reset with reads in flight and a write presented on the reset cycle
    reset = 1'b1;
    issue(8'h24, 4'hF, 32'h5555AAAA);
    step();
    nChecks++;
    if (ifA.rsp_valid !== 1'b0 || ifB.rsp_valid !== 1'b0 || ifA.req_ready !== 1'b0 || ifB.req_ready !== 1'b0) begin
      nErrors++;
      $display("FAIL midreset_flush: validA=%b validB=%b readyA=%b readyB=%b, required all 0",
               ifA.rsp_valid, ifB.rsp_valid, ifA.req_ready, ifB.req_ready);
    end
    nChecks++;
    if (ifA.rsp_rdata !== 32'h0 || ifB.rsp_rdata !== 32'h0 || ifA.rsp_err !== 1'b0) begin
      nErrors++;
      $display("FAIL midreset_data: rdataA=%h rdataB=%h errA=%b, required 0", ifA.rsp_rdata, ifB.rsp_rdata, ifA.rsp_err);
    end
    reset = 1'b0;
    idle();
    model_clear();
    for (int k = 1; k <= DEPTH; k++) begin
      step();
      expRdy = (k == DEPTH);
      nChecks++;
      if (ifA.rsp_valid !== 1'b0 || ifB.rsp_valid !== 1'b0) begin
        nErrors++; $display("FAIL midreset_norsp cycle %0d: validA=%b validB=%b, required 0", k, ifA.rsp_valid, ifB.rsp_valid);
      end
      nChecks++;
      if (ifA.req_ready !== expRdy || ifB.init_done !== expRdy) begin
        nErrors++; $display("FAIL midreset_sweep cycle %0d: readyA=%b doneB=%b, required %b", k, ifA.req_ready, ifB.init_done, expRdy);
      end
    end
    // previously written words read back cleared
    t.push_back('{8'h20, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0});
    t.push_back('{8'h10, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0});
    t.push_back('{8'h24, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0});
    foreach (t[i]) model_access(t[i].a, t[i].w, t[i].d);
    n = t.size();
    for (int k = 0; k <= n; k++) begin
      if (k < n) issue(t[k].a, t[k].w, t[k].d); else idle();
      step();
      nChecks++;
      if (ifA.rsp_valid !== (k < n)) begin
        nErrors++; $display("FAIL postreset_validA k=%0d: got %b, required %b", k, ifA.rsp_valid, (k < n));
      end
      if (k < n) begin
        nChecks++;
        if (ifA.rsp_rdata !== t[k].xa || ifA.rsp_err !== t[k].ea) begin
          nErrors++; $display("FAIL postreset_dataA k=%0d: got %h err=%b, required %h err=%b", k, ifA.rsp_rdata, ifA.rsp_err, t[k].xa, t[k].ea);
        end
      end
      nChecks++;
      if (ifB.rsp_valid !== (k >= 1)) begin
        nErrors++; $display("FAIL postreset_validB k=%0d: got %b, required %b", k, ifB.rsp_valid, (k >= 1));
      end
      if (k >= 1) begin
        nChecks++;
        if (ifB.rsp_rdata !== t[k-1].xb || ifB.rsp_err !== t[k-1].eb) begin
          nErrors++; $display("FAIL postreset_dataB k=%0d: got %h err=%b, required %h err=%b", k, ifB.rsp_rdata, ifB.rsp_err, t[k-1].xb, t[k-1].eb);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lane_merge();
    test_rdw_mode();
    test_align();
    test_back_to_back();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
